bitrev_rr_sched: RTL and testbench

Round-robin scheduler that shares one bit-reversal datapath among `NUM_REQ` requesters. Each requester offers a word over a valid/ready handshake. One word per cycle is granted, and its bit-reversed value (`dout[i] = din[DATA_WIDTH-1-i]`) is written into a single registered output stage, tagged with the requester index. It sits between multiple producer channels and one shared downstream consumer.

---
 rtl/bitrev_rr_sched.sv | 84 ++++++++
 tb/tb_bitrev_rr_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_rr_sched.sv
// Round-robin arbiter feeding one shared bit-reversal stage.
// One registered result slot, tagged with the id of the requester that won.
module bitrev_rr_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [ID_WIDTH-1:0]           out_id,
   output logic [15:0]                   xfer_cnt
);

   logic [DATA_WIDTH-1:0] words [NUM_REQ];
   logic [DATA_WIDTH-1:0] rev;
   logic [ID_WIDTH-1:0]   last_grant;
   logic [ID_WIDTH-1:0]   gidx;
   logic [ID_WIDTH-1:0]   slot;
   logic [NUM_REQ-1:0]    grant;
   logic                  found;
   logic                  can_accept;
   logic                  accept;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   assign can_accept = !out_valid || out_ready;

   // Search starts one past the last winner and wraps, so every
   // waiting requester is served within NUM_REQ accepts.
   always_comb begin
      grant = '0;
      gidx  = '0;
      slot  = '0;
      found = 1'b0;
      if (can_accept && resetn) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            slot = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[slot]) begin
               found       = 1'b1;
               grant[slot] = 1'b1;
               gidx        = slot;
            end
         end
      end
   end

   assign req_ready = grant;
   assign accept    = found;

   always_comb begin
      rev = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         rev[i] = words[gidx][DATA_WIDTH-1-i];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_id     <= '0;
         xfer_cnt   <= '0;
         last_grant <= ID_WIDTH'(NUM_REQ - 1);
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_data   <= rev;
         out_id     <= gidx;
         last_grant <= gidx;
         xfer_cnt   <= xfer_cnt + 16'd1;
      end else if (out_ready) begin
         // Drained with nothing new: data and id keep their last values.
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bitrev_rr_sched.sv
// Directed bench for bitrev_rr_sched: a 4-requester instance for
// arbitration/backpressure and a 1-requester instance for counter wrap.
module tb_bitrev_rr_sched;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic [3:0]   req_valid = '0;
   logic [127:0] req_data = '0;
   logic [3:0]   req_ready;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [31:0]  out_data;
   logic [1:0]   out_id;
   logic [15:0]  xfer_cnt;

   logic         v1 = 1'b0;
   logic [7:0]   d1 = '0;
   logic         rdy1;
   logic         ov1;
   logic         or1 = 1'b1;
   logic [7:0]   od1;
   logic         id1;
   logic [15:0]  cnt1;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   bitrev_rr_sched #(.DATA_WIDTH(32), .NUM_REQ(4)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_id(out_id), .xfer_cnt(xfer_cnt)
   );

   bitrev_rr_sched #(.DATA_WIDTH(8), .NUM_REQ(1)) dut1 (
      .clk(clk), .resetn(resetn),
      .req_valid(v1), .req_data(d1), .req_ready(rdy1),
      .out_valid(ov1), .out_ready(or1),
      .out_data(od1), .out_id(id1), .xfer_cnt(cnt1)
   );

   task automatic set_word(input int i, input logic [31:0] w);
      req_data[i*32 +: 32] = w;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      req_valid = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      req_valid = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if (req_ready !== 4'b0000)
         $display("FAIL reset_ready got %b want 0000", req_ready);
      else n_pass++;
      n_total++;
      if ({out_valid, out_data, out_id, xfer_cnt} !== 51'd0)
         $display("FAIL reset_regs got v=%b d=%h id=%0d c=%0d want all 0",
                  out_valid, out_data, out_id, xfer_cnt);
      else n_pass++;
      req_valid = '0;
      #1 resetn = 1'b1;
      #1;
   endtask

   task automatic test_single_word();
      do_reset();
      set_word(2, 32'h1234_5678);
      req_valid = 4'b0100;
      #1;
      n_total++;
      if (req_ready !== 4'b0100)
         $display("FAIL single_ready got %b want 0100", req_ready);
      else n_pass++;
      tick();
      req_valid = '0;
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 32'h1E6A_2C48 ||
          out_id !== 2'd2 || xfer_cnt !== 16'd1)
         $display("FAIL single_out got v=%b d=%h id=%0d c=%0d want 1 1e6a2c48 2 1",
                  out_valid, out_data, out_id, xfer_cnt);
      else n_pass++;
      tick();
      n_total++;
      if (out_valid !== 1'b0 || out_data !== 32'h1E6A_2C48)
         $display("FAIL single_drain got v=%b d=%h want 0 1e6a2c48",
                  out_valid, out_data);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_id [6]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      logic [31:0] exp_d  [4]   = '{32'h8000_0000, 32'h4000_0000,
                                    32'h2000_0000, 32'h1000_0000};
      do_reset();
      set_word(0, 32'h1);
      set_word(1, 32'h2);
      set_word(2, 32'h4);
      set_word(3, 32'h8);
      req_valid = 4'hF;
      for (int k = 0; k < 6; k++) begin
         tick();
         n_total++;
         if (out_valid !== 1'b1 || out_id !== exp_id[k] ||
             out_data !== exp_d[exp_id[k]])
            $display("FAIL rr_step%0d got v=%b id=%0d d=%h want 1 %0d %h",
                     k, out_valid, out_id, out_data, exp_id[k], exp_d[exp_id[k]]);
         else n_pass++;
      end
      n_total++;
      if (xfer_cnt !== 16'd6)
         $display("FAIL rr_count got %0d want 6", xfer_cnt);
      else n_pass++;
      req_valid = '0;
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      set_word(0, 32'h1);
      set_word(1, 32'h2);
      req_valid = 4'b0011;
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_total++;
         if (req_ready !== 4'b0000 || out_valid !== 1'b1 ||
             out_data !== 32'h8000_0000 || out_id !== 2'd0 ||
             xfer_cnt !== 16'd1)
            $display("FAIL bp_hold%0d got r=%b v=%b d=%h id=%0d c=%0d want 0000 1 80000000 0 1",
                     k, req_ready, out_valid, out_data, out_id, xfer_cnt);
         else n_pass++;
         tick();
      end
      out_ready = 1'b1;
      #1;
      n_total++;
      if (req_ready !== 4'b0010)
         $display("FAIL bp_release_ready got %b want 0010", req_ready);
      else n_pass++;
      tick();
      req_valid = '0;
      n_total++;
      if (out_id !== 2'd1 || out_data !== 32'h4000_0000 || xfer_cnt !== 16'd2)
         $display("FAIL bp_release_out got id=%0d d=%h c=%0d want 1 40000000 2",
                  out_id, out_data, xfer_cnt);
      else n_pass++;
      tick();
   endtask

   task automatic test_pointer_hold();
      do_reset();
      set_word(1, 32'h2);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      repeat (5) tick();
      set_word(0, 32'h1);
      set_word(3, 32'h8);
      req_valid = 4'b1001;
      #1;
      n_total++;
      if (req_ready !== 4'b1000)
         $display("FAIL hold_ready got %b want 1000", req_ready);
      else n_pass++;
      tick();
      req_valid = 4'b0001;
      n_total++;
      if (out_id !== 2'd3 || out_data !== 32'h1000_0000)
         $display("FAIL hold_first got id=%0d d=%h want 3 10000000", out_id, out_data);
      else n_pass++;
      tick();
      req_valid = '0;
      n_total++;
      if (out_id !== 2'd0 || out_data !== 32'h8000_0000)
         $display("FAIL hold_second got id=%0d d=%h want 0 80000000", out_id, out_data);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_word(0, 32'h1);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      resetn = 1'b0;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || xfer_cnt !== 16'd0)
         $display("FAIL midrst_async got v=%b d=%h c=%0d want 0 0 0",
                  out_valid, out_data, xfer_cnt);
      else n_pass++;
      set_word(3, 32'h8);
      req_valid = 4'b1001;
      @(posedge clk);
      #1 resetn = 1'b1;
      #1;
      n_total++;
      if (req_ready !== 4'b0001)
         $display("FAIL midrst_ready got %b want 0001", req_ready);
      else n_pass++;
      tick();
      req_valid = 4'b1000;
      n_total++;
      if (out_id !== 2'd0)
         $display("FAIL midrst_first got id=%0d want 0", out_id);
      else n_pass++;
      tick();
      req_valid = '0;
      n_total++;
      if (out_id !== 2'd3)
         $display("FAIL midrst_second got id=%0d want 3", out_id);
      else n_pass++;
      tick();
   endtask

   task automatic test_counter_wrap();
      int bad = 0;
      do_reset();
      d1  = 8'h01;
      v1  = 1'b1;
      or1 = 1'b1;
      #1;
      n_total++;
      if (rdy1 !== 1'b1)
         $display("FAIL wrap_ready got %b want 1", rdy1);
      else n_pass++;
      tick();
      n_total++;
      if (ov1 !== 1'b1 || od1 !== 8'h80 || id1 !== 1'b0 || cnt1 !== 16'd1)
         $display("FAIL wrap_first got v=%b d=%h id=%0d c=%0d want 1 80 0 1",
                  ov1, od1, id1, cnt1);
      else n_pass++;
      for (int k = 1; k < 65536; k++) begin
         tick();
         if (id1 !== 1'b0) bad++;
      end
      n_total++;
      if (cnt1 !== 16'h0000 || ov1 !== 1'b1)
         $display("FAIL wrap_count got c=%h v=%b want 0000 1", cnt1, ov1);
      else n_pass++;
      n_total++;
      if (bad !== 0)
         $display("FAIL wrap_id got %0d nonzero ids want 0", bad);
      else n_pass++;
      v1 = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_round_robin();
      test_backpressure();
      test_pointer_hold();
      test_reset_mid();
      test_counter_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
